// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, IF/ID pipeline register and fetch counter with stall/flush/redirect.
// Define FETCH_HALT_EN to stop fetching once the PC runs past the end of the instruction image.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 156,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic [31:0] Instruction,
  output logic [63:0] Inst_Address,
  output logic [63:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid,
  output logic [31:0] Fetch_Count,
  output logic        Halted
);
  logic [63:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, tgt;
  logic [31:0] ifid_instr_q, ifid_instr_d, cnt_q, cnt_d;
  logic        ifid_valid_q, ifid_valid_d, halt_q, halt_nx, load, bubble;
  assign tgt = Branch_Target & ~64'd3;
`ifdef FETCH_HALT_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && !Branch_Taken && !Stall && pc_q >= 64'(IMEM_BYTES)) state_d = HALT;
    else if (state_q == HALT && Branch_Taken && tgt < 64'(IMEM_BYTES)) state_d = RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= RUN;
    else state_q <= state_d;
  assign halt_q  = state_q == HALT;
  assign halt_nx = state_d == HALT;
`else
  assign halt_q  = 1'b0;
  assign halt_nx = 1'b0;
`endif
  // Flush beats stall; a halted front end only feeds bubbles.
  always_comb begin
    pc_d         = Branch_Taken ? tgt : (Stall || halt_nx) ? pc_q : pc_q + 64'd4;
    load         = !Flush && !Stall && !halt_q && !halt_nx;
    bubble       = Flush || (!Stall && (halt_q || halt_nx));
    ifid_pc_d    = load ? pc_q : bubble ? 64'd0 : ifid_pc_q;
    ifid_instr_d = load ? Instruction : bubble ? NOP_WORD : ifid_instr_q;
    ifid_valid_d = load ? 1'b1 : bubble ? 1'b0 : ifid_valid_q;
    cnt_d        = (load && cnt_q != 32'hFFFFFFFF) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'd0;
      ifid_instr_q <= NOP_WORD;
      ifid_valid_q <= 1'b0;
      cnt_q        <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      cnt_q        <= cnt_d;
    end
  assign Inst_Address      = pc_q;
  assign IF_ID_PC          = ifid_pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_Valid       = ifid_valid_q;
  assign Fetch_Count       = cnt_q;
  assign Halted            = halt_q;
endmodule
